operand_forward_checker: RTL and testbench
==========================================

Name: operand_forward_checker

Overview:
- Parametrised, synthesizable runtime checker for the RV32IMA pipeline's operand forwarding; sits beside the datapath, observing the EX stage and the N downstream forwarding stages.
- Keeps a shadow register file updated at writeback and computes the architecturally correct value for every EX source operand.
- Flags a mismatch against the value the ALU actually received, and flags a RAW hazard when the producer's result was not yet available.
- Generalises the fixed two-operand MEM/WB property checks to configurable operand count, stage count and width, with per-register validity tracking and error capture.

Parameters:
- XLEN, 32, datapath width.
- NUM_SRC, 2, source operands checked per EX instruction.
- NUM_FWD, 2, forwarding stages; index 0 is youngest (MEM), NUM_FWD-1 is WB.
- NREGS, 32, architectural registers; address width AW = clog2(NREGS).
- CNT_W, 16, width of the error and check counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- ex_valid_i  in  1  EX holds a valid instruction.
- stall_i  in  1  EX is stalled this cycle.
- flush_i  in  1  EX is being flushed this cycle.
- ex_rs_used_i  in  NUM_SRC  source s is read by the instruction.
- ex_rs_addr_i  in  NUM_SRC*AW  source register addresses.
- ex_operand_i  in  NUM_SRC*XLEN  operand values at the ALU input (post-forward mux).
- fwd_valid_i  in  NUM_FWD  stage k holds a register-writing instruction.
- fwd_ready_i  in  NUM_FWD  stage k's result is available (0 for a load still in MEM).
- fwd_rd_i  in  NUM_FWD*AW  destination address per stage.
- fwd_data_i  in  NUM_FWD*XLEN  result per stage.
- wb_commit_i  in  1  writeback commits this cycle.
- wb_rd_i  in  AW  writeback destination address.
- wb_data_i  in  XLEN  writeback data.
- mismatch_o  out  NUM_SRC  per-source mismatch pulse.
- hazard_o  out  NUM_SRC  per-source unresolved-hazard pulse.
- err_count_o  out  CNT_W  saturating count of flagged sources.
- check_count_o  out  CNT_W  saturating count of compared sources.
- first_err_valid_o  out  1  sticky; first error has been captured.
- first_err_src_o  out  clog2(NUM_SRC)  source index of the first error (min width 1).
- first_err_addr_o  out  AW  register address of the first error.
- first_err_exp_o  out  XLEN  expected value of the first error.
- first_err_act_o  out  XLEN  actual value of the first error.

Behaviour:
- Reset (synchronous, reset==0): all outputs 0; shadow register file cleared; per-register valid bits cleared.
- Shadow update, at the clock edge: if wb_commit_i and wb_rd_i != 0, write wb_data_i and set valid[wb_rd_i]. Register x0 always reads 0 and is always valid.
- Check event for source s: ex_valid_i && !stall_i && !flush_i && ex_rs_used_i[s].
- Expected-value resolution for a check event (combinational):
  - addr == 0 gives expected 0.
  - Otherwise, scan k = 0..NUM_FWD-1 and take the first k with fwd_valid_i[k] && fwd_rd_i[k] == addr.
  - If that stage has fwd_ready_i set, expected = fwd_data_i[k]; otherwise the event is a hazard and no compare is made.
  - If no stage matches, expected = shadow[addr], read from pre-edge contents. A same-cycle WB is already covered by stage NUM_FWD-1.
  - If no stage matches and valid[addr]==0 (never written since reset), the source is skipped: no compare, no count.
- Latency: 1 cycle. Compare results are registered; mismatch_o and hazard_o pulse for exactly one cycle in the cycle after the event, then return to 0.
- Counters:
  - check_count_o increments by the number of compared sources in a cycle.
  - err_count_o increments by the number of mismatches plus hazards in a cycle.
  - Both saturate at all-ones.
- First-error capture:
  - When first_err_valid_o is 0 and any source flags, capture the lowest flagging index s.
  - For a hazard, exp holds the stage's data and act holds the operand.
  - Hold all captured fields until reset; later errors never overwrite them.
- stall_i or flush_i suppress checks in that cycle only; shadow updates continue regardless.
- A reset asserted mid-stream discards any pending registered pulse.

Test Plan:
- MEM forward: stage0 valid, ready, rd=5, data=0x11; EX rs1=5, operand 0x11 -> next cycle mismatch_o=0, check_count_o=1. Repeat with operand 0x12 -> mismatch_o[0]=1, err_count_o=1, first_err captures addr=5, exp=0x11, act=0x12.
- Priority: stage0 rd=7 data=0xA, stage1 rd=7 data=0xB, operand=0xB -> mismatch flagged, exp=0xA.
- Load-use: stage0 rd=3, fwd_ready_i[0]=0, EX rs2=3 -> hazard_o[1]=1, no compare, check_count_o unchanged.
- Shadow path and warm-up: read x9 before any write -> skipped, counters 0. Commit x9=0xDEAD, then EX rs1=9 with operand 0xDEAD and no forward match -> pass, check_count_o=1.
- x0 and simultaneous errors: rs1=0 with operand 0x1 and rs2 mismatching in the same cycle -> mismatch_o=2'b11, err_count_o+=2, first_err_src_o=0.
- Stall/flush/reset: a mismatching operand with stall_i=1 -> no flag; saturation at CNT_W=4 holds at 15 over 20 errors; reset mid-run clears all outputs.

Source files
------------

// File: rtl/operand_forward_checker.sv
// Runtime checker for EX-stage operand forwarding: tracks a shadow register file,
// resolves the architecturally correct value of each source and flags mismatches/hazards.
module operand_forward_checker #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int NREGS   = 32,
  parameter int CNT_W   = 16,
  localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_valid_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [NUM_SRC-1:0]      ex_rs_used_i,
  input  logic [NUM_SRC*AW-1:0]   ex_rs_addr_i,
  input  logic [NUM_SRC*XLEN-1:0] ex_operand_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [NUM_FWD-1:0]      fwd_ready_i,
  input  logic [NUM_FWD*AW-1:0]   fwd_rd_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
  input  logic                    wb_commit_i,
  input  logic [AW-1:0]           wb_rd_i,
  input  logic [XLEN-1:0]         wb_data_i,
  output logic [NUM_SRC-1:0]      mismatch_o,
  output logic [NUM_SRC-1:0]      hazard_o,
  output logic [CNT_W-1:0]        err_count_o,
  output logic [CNT_W-1:0]        check_count_o,
  output logic                    first_err_valid_o,
  output logic [SW-1:0]           first_err_src_o,
  output logic [AW-1:0]           first_err_addr_o,
  output logic [XLEN-1:0]         first_err_exp_o,
  output logic [XLEN-1:0]         first_err_act_o
);

  localparam int NW = $clog2(NUM_SRC + 1);

  logic [XLEN-1:0]    shadow_reg [NREGS];
  logic [NREGS-1:0]   valid_reg;

  logic [NUM_SRC-1:0] cmp_vec;
  logic [NUM_SRC-1:0] haz_vec;
  logic [NUM_SRC-1:0] mis_vec;
  logic [NUM_SRC-1:0] flag_vec;
  logic [XLEN-1:0]    exp_arr  [NUM_SRC];
  logic [XLEN-1:0]    act_arr  [NUM_SRC];
  logic [AW-1:0]      addr_arr [NUM_SRC];

  logic               check_go;
  assign check_go = ex_valid_i && !stall_i && !flush_i;

  // Shadow register file; writes keep going even while EX is stalled or flushed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow_reg[i] <= '0;
      end
      valid_reg <= '0;
    end else if (wb_commit_i && wb_rd_i != '0) begin
      shadow_reg[wb_rd_i] <= wb_data_i;
      valid_reg[wb_rd_i]  <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] act;
    logic            hit;
    logic            hit_ready;
    logic [XLEN-1:0] hit_data;
    logic            cmp_l;
    logic            haz_l;
    logic [XLEN-1:0] exp_l;

    assign addr = ex_rs_addr_i[gi*AW +: AW];
    assign act  = ex_operand_i[gi*XLEN +: XLEN];

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_data  = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_valid_i[k] && fwd_rd_i[k*AW +: AW] == addr) begin
          hit       = 1'b1;
          hit_ready = fwd_ready_i[k];
          hit_data  = fwd_data_i[k*XLEN +: XLEN];
        end
      end
    end

    always_comb begin
      cmp_l = 1'b0;
      haz_l = 1'b0;
      exp_l = '0;
      if (check_go && ex_rs_used_i[gi]) begin
        if (addr == '0) begin
          cmp_l = 1'b1;
        end else if (hit) begin
          exp_l = hit_data;
          cmp_l = hit_ready;
          haz_l = !hit_ready;
        end else if (valid_reg[addr]) begin
          cmp_l = 1'b1;
          exp_l = shadow_reg[addr];
        end
      end
    end

    assign cmp_vec[gi]  = cmp_l;
    assign haz_vec[gi]  = haz_l;
    assign mis_vec[gi]  = cmp_l && (exp_l != act);
    assign exp_arr[gi]  = exp_l;
    assign act_arr[gi]  = act;
    assign addr_arr[gi] = addr;
  end

  assign flag_vec = mis_vec | haz_vec;

  logic [NW-1:0] n_cmp;
  logic [NW-1:0] n_flag;

  always_comb begin
    n_cmp  = '0;
    n_flag = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      n_cmp  = n_cmp  + NW'(cmp_vec[i]);
      n_flag = n_flag + NW'(flag_vec[i]);
    end
  end

  logic [CNT_W+NW-1:0] chk_sum;
  logic [CNT_W+NW-1:0] err_sum;
  logic [CNT_W-1:0]    chk_next;
  logic [CNT_W-1:0]    err_next;

  always_comb begin
    chk_sum  = {{NW{1'b0}}, check_count_o} + {{CNT_W{1'b0}}, n_cmp};
    err_sum  = {{NW{1'b0}}, err_count_o}   + {{CNT_W{1'b0}}, n_flag};
    chk_next = (|chk_sum[CNT_W+NW-1:CNT_W]) ? '1 : chk_sum[CNT_W-1:0];
    err_next = (|err_sum[CNT_W+NW-1:CNT_W]) ? '1 : err_sum[CNT_W-1:0];
  end

  // Lowest flagging source index is the one recorded as the first error.
  logic [SW-1:0]   sel_src;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_exp;
  logic [XLEN-1:0] sel_act;

  always_comb begin
    sel_src  = '0;
    sel_addr = '0;
    sel_exp  = '0;
    sel_act  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (flag_vec[i]) begin
        sel_src  = SW'(i);
        sel_addr = addr_arr[i];
        sel_exp  = exp_arr[i];
        sel_act  = act_arr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mismatch_o        <= '0;
      hazard_o          <= '0;
      err_count_o       <= '0;
      check_count_o     <= '0;
      first_err_valid_o <= 1'b0;
      first_err_src_o   <= '0;
      first_err_addr_o  <= '0;
      first_err_exp_o   <= '0;
      first_err_act_o   <= '0;
    end else begin
      mismatch_o    <= mis_vec;
      hazard_o      <= haz_vec;
      err_count_o   <= err_next;
      check_count_o <= chk_next;
      if (!first_err_valid_o && |flag_vec) begin
        first_err_valid_o <= 1'b1;
        first_err_src_o   <= sel_src;
        first_err_addr_o  <= sel_addr;
        first_err_exp_o   <= sel_exp;
        first_err_act_o   <= sel_act;
      end
    end
  end

endmodule

// File: tb/tb_operand_forward_checker.sv
// Scoreboard bench: driver pushes model predictions per cycle, monitor pops and compares.
module tb_operand_forward_checker;
  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int NF   = 2;
  localparam int NR   = 32;
  localparam int CW   = 4;
  localparam int AW   = 5;
  localparam int SW   = 1;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 ex_valid, stall, flush;
  logic [NS-1:0]        rs_used;
  logic [NS*AW-1:0]     rs_addr;
  logic [NS*XLEN-1:0]   operand;
  logic [NF-1:0]        fwd_valid, fwd_ready;
  logic [NF*AW-1:0]     fwd_rd;
  logic [NF*XLEN-1:0]   fwd_data;
  logic                 wb_commit;
  logic [AW-1:0]        wb_rd;
  logic [XLEN-1:0]      wb_data;

  logic [NS-1:0]   mismatch, hazard;
  logic [CW-1:0]   err_count, check_count;
  logic            fe_valid;
  logic [SW-1:0]   fe_src;
  logic [AW-1:0]   fe_addr;
  logic [XLEN-1:0] fe_exp, fe_act;

  operand_forward_checker #(
    .XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD(NF), .NREGS(NR), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_valid_i(ex_valid), .stall_i(stall), .flush_i(flush),
    .ex_rs_used_i(rs_used), .ex_rs_addr_i(rs_addr), .ex_operand_i(operand),
    .fwd_valid_i(fwd_valid), .fwd_ready_i(fwd_ready), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
    .wb_commit_i(wb_commit), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .mismatch_o(mismatch), .hazard_o(hazard),
    .err_count_o(err_count), .check_count_o(check_count),
    .first_err_valid_o(fe_valid), .first_err_src_o(fe_src), .first_err_addr_o(fe_addr),
    .first_err_exp_o(fe_exp), .first_err_act_o(fe_act)
  );

  typedef struct {
    logic [NS-1:0]   mis;
    logic [NS-1:0]   haz;
    int              err;
    int              chk;
    bit              fev;
    int              fsrc;
    logic [AW-1:0]   faddr;
    logic [XLEN-1:0] fexp;
    logic [XLEN-1:0] fact;
  } exp_t;

  exp_t sb[$];

  // Reference model state: architectural register file as seen by writeback.
  logic [XLEN-1:0] m_reg [NR];
  bit              m_val [NR];
  int              m_err, m_chk, m_fsrc;
  bit              m_fev;
  logic [AW-1:0]   m_faddr;
  logic [XLEN-1:0] m_fexp, m_fact;

  int n_pass = 0;
  int n_tot  = 0;
  int n_txn  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (txn %0d)", nm, act, expv, n_txn);
  endtask

  // What the architecture says source s should hold this cycle.
  task automatic resolve(input int s, output bit comp, output bit haz, output logic [XLEN-1:0] ev);
    logic [AW-1:0] a;
    int hit;
    comp = 0; haz = 0; ev = '0;
    if (!(ex_valid && !stall && !flush && rs_used[s])) return;
    a = rs_addr[s*AW +: AW];
    hit = -1;
    for (int k = 0; k < NF; k++)
      if (hit < 0 && fwd_valid[k] && fwd_rd[k*AW +: AW] == a) hit = k;
    if (a == 0) comp = 1;
    else if (hit >= 0) begin
      ev = fwd_data[hit*XLEN +: XLEN];
      if (fwd_ready[hit]) comp = 1; else haz = 1;
    end else if (m_val[a]) begin
      comp = 1;
      ev = m_reg[a];
    end
  endtask

  task automatic issue();
    exp_t e;
    bit comp, haz;
    logic [XLEN-1:0] ev, act;
    if (!reset) begin
      for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_val[i] = 0; end
      m_err = 0; m_chk = 0; m_fev = 0; m_fsrc = 0; m_faddr = '0; m_fexp = '0; m_fact = '0;
      e.mis = '0; e.haz = '0;
    end else begin
      e.mis = '0; e.haz = '0;
      for (int s = 0; s < NS; s++) begin
        resolve(s, comp, haz, ev);
        act = operand[s*XLEN +: XLEN];
        if (comp) m_chk = (m_chk + 1 > CMAX) ? CMAX : m_chk + 1;
        if (comp && ev != act) e.mis[s] = 1'b1;
        if (haz) e.haz[s] = 1'b1;
        if (e.mis[s] || e.haz[s]) begin
          m_err = (m_err + 1 > CMAX) ? CMAX : m_err + 1;
          if (!m_fev) begin
            m_fev = 1; m_fsrc = s; m_faddr = rs_addr[s*AW +: AW]; m_fexp = ev; m_fact = act;
          end
        end
      end
      if (wb_commit && wb_rd != 0) begin
        m_reg[wb_rd] = wb_data;
        m_val[wb_rd] = 1;
      end
    end
    e.err = m_err; e.chk = m_chk; e.fev = m_fev; e.fsrc = m_fsrc;
    e.faddr = m_faddr; e.fexp = m_fexp; e.fact = m_fact;
    sb.push_back(e);
  endtask

  task automatic cyc();
    issue();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1; ex_valid = 0; stall = 0; flush = 0;
    rs_used = '0; rs_addr = '0; operand = '0;
    fwd_valid = '0; fwd_ready = '0; fwd_rd = '0; fwd_data = '0;
    wb_commit = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic set_src(input int s, input logic [AW-1:0] a, input logic [XLEN-1:0] v);
    ex_valid = 1;
    rs_used[s] = 1'b1;
    rs_addr[s*AW +: AW] = a;
    operand[s*XLEN +: XLEN] = v;
  endtask

  task automatic set_fwd(input int k, input bit rdy, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    fwd_valid[k] = 1'b1;
    fwd_ready[k] = rdy;
    fwd_rd[k*AW +: AW] = a;
    fwd_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic do_reset(input int n);
    idle(); reset = 0;
    for (int i = 0; i < n; i++) cyc();
    idle();
  endtask

  // Monitor: outputs are stable one time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_txn++;
        chk("mismatch_o", 64'(mismatch), 64'(e.mis));
        chk("hazard_o", 64'(hazard), 64'(e.haz));
        chk("err_count_o", 64'(err_count), 64'(e.err));
        chk("check_count_o", 64'(check_count), 64'(e.chk));
        chk("first_err_valid_o", 64'(fe_valid), 64'(e.fev));
        chk("first_err_src_o", 64'(fe_src), 64'(e.fsrc));
        chk("first_err_addr_o", 64'(fe_addr), 64'(e.faddr));
        chk("first_err_exp_o", 64'(fe_exp), 64'(e.fexp));
        chk("first_err_act_o", 64'(fe_act), 64'(e.fact));
        $display("txn %0d mis=%b haz=%b err=%0d chk=%0d fev=%b", n_txn, mismatch, hazard,
                 err_count, check_count, fe_valid);
      end
    end
  end

  initial begin
    bit comp, haz;
    logic [XLEN-1:0] ev;
    idle();
    reset = 0;
    @(negedge clk);
    do_reset(2);

    // MEM forward: matching then mismatching operand
    set_fwd(0, 1, 5'd5, 32'h11); set_src(0, 5'd5, 32'h11); cyc();
    set_src(0, 5'd5, 32'h12); cyc();
    idle(); cyc();

    // Youngest stage wins over WB
    set_fwd(0, 1, 5'd7, 32'hA); set_fwd(1, 1, 5'd7, 32'hB); set_src(0, 5'd7, 32'hB); cyc();
    idle();

    // Load-use hazard on rs2
    set_fwd(0, 0, 5'd3, 32'h33); set_src(1, 5'd3, 32'h44); cyc();
    idle(); cyc();

    // Shadow warm-up and shadow path
    do_reset(1);
    set_src(0, 5'd9, 32'h1); cyc();
    idle(); wb_commit = 1; wb_rd = 5'd9; wb_data = 32'hDEAD; cyc();
    idle(); set_src(0, 5'd9, 32'hDEAD); cyc();

    // x0 and simultaneous errors
    idle(); set_src(0, 5'd0, 32'h1); set_src(1, 5'd9, 32'hBEEF); cyc();

    // Stall and flush suppress checks; shadow still updates under stall
    idle(); set_src(0, 5'd0, 32'h5); stall = 1; wb_commit = 1; wb_rd = 5'd4; wb_data = 32'h44; cyc();
    idle(); set_src(0, 5'd0, 32'h5); flush = 1; cyc();
    idle(); set_src(0, 5'd4, 32'h44); cyc();
    idle(); cyc();

    // Saturation over 20 errors
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      idle(); set_src(0, 5'd0, 32'(i + 1)); set_src(1, 5'd0, 32'h0); cyc();
    end

    // Reset right after an error discards the pending pulse
    idle(); set_src(0, 5'd0, 32'h7); cyc();
    idle(); reset = 0; set_src(0, 5'd0, 32'h7); cyc();
    idle(); cyc();

    // Randomized traffic over a small register window to hit forwarding often
    for (int c = 0; c < 400; c++) begin
      idle();
      reset    = ($urandom_range(0, 39) != 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < NF; k++)
        if ($urandom_range(0, 1) == 1)
          set_fwd(k, $urandom_range(0, 4) != 0, AW'($urandom_range(0, 7)), $urandom);
      for (int s = 0; s < NS; s++) begin
        rs_used[s] = ($urandom_range(0, 3) != 0);
        rs_addr[s*AW +: AW] = AW'($urandom_range(0, 7));
      end
      wb_commit = ($urandom_range(0, 1) == 1);
      wb_rd     = AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      for (int s = 0; s < NS; s++) begin
        resolve(s, comp, haz, ev);
        operand[s*XLEN +: XLEN] = (comp && $urandom_range(0, 3) != 0) ? ev : $urandom;
      end
      cyc();
    end

    idle();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
